// File: rtl/npu_sig_pkg.sv
// Shared definitions for the NPU DRAM output signature block.
//   sig_state_e : capture FSM states (collect, one-cycle drain, done/frozen)
//   DefaultPoly : default MISR feedback polynomial (CRC-32 polynomial)
//   DefaultSeed : default signature value after reset or clear
//   misr_step() : one MISR update, width-generic up to SigMax bits
package npu_sig_pkg;

   typedef enum logic [1:0] {
      StCollect,
      StDrain,
      StDone
   } sig_state_e;

   localparam logic [31:0] DefaultPoly = 32'h04C11DB7;
   localparam logic [31:0] DefaultSeed = 32'hFFFFFFFF;

   // Widest signature misr_step() can handle; callers zero-extend into it.
   localparam int unsigned SigMax = 64;

   // Shift left, fold in the polynomial when the bit shifted out was set, then
   // mix in the new data word. Bits at and above 'width' are masked off.
   function automatic logic [SigMax-1:0] misr_step(input logic [SigMax-1:0] sig,
                                                    input logic [SigMax-1:0] data,
                                                    input logic [SigMax-1:0] poly,
                                                    input int unsigned       width);
      logic [SigMax-1:0] nxt;
      logic [SigMax-1:0] mask;
      // For width == SigMax the shift yields 0 and the subtraction wraps to all ones.
      mask = (SigMax'(1) << width) - SigMax'(1);
      nxt  = (sig << 1) ^ data;
      if (sig[width-1]) begin
         nxt = nxt ^ poly;
      end
      return nxt & mask;
   endfunction

endpackage

// File: rtl/sig_fold.sv
// Stage 1 of the signature pipeline: folds a DWIDTH-bit write and its address
// into one SIG_WIDTH-bit word and registers it.
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : drops any registered entry (synchronous)
//   load      : write accepted this cycle; capture the folded word
//   wr_addr   : DRAM address, XORed into the low AWIDTH bits of the fold
//   wr_data   : DRAM write data, XOR-folded SIG_WIDTH bits at a time
//   s1_fold   : registered folded word
//   s1_valid  : s1_fold holds an entry the MISR must consume this cycle
module sig_fold #(
   parameter int DWIDTH    = 512,
   parameter int AWIDTH    = 9,
   parameter int SIG_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 load,
   input  logic [AWIDTH-1:0]    wr_addr,
   input  logic [DWIDTH-1:0]    wr_data,
   output logic [SIG_WIDTH-1:0] s1_fold,
   output logic                 s1_valid
);

   localparam int NumWords = DWIDTH / SIG_WIDTH;

   logic [SIG_WIDTH-1:0] fold_d;
   logic [SIG_WIDTH-1:0] fold_q;
   logic                 valid_q;

   always_comb begin
      fold_d = '0;
      for (int i = 0; i < NumWords; i++) begin
         fold_d = fold_d ^ wr_data[i*SIG_WIDTH +: SIG_WIDTH];
      end
      fold_d[AWIDTH-1:0] = fold_d[AWIDTH-1:0] ^ wr_addr;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fold_q  <= '0;
         valid_q <= 1'b0;
      end else if (flush) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= load;
         if (load) begin
            fold_q <= fold_d;
         end
      end
   end

   assign s1_fold  = fold_q;
   assign s1_valid = valid_q;

endmodule

// File: rtl/npu_dram_out_signature.sv
// Compresses every NPU DRAM write (data + address) into a MISR signature over a
// bounded capture window, then freezes the signature and raises sig_valid.
//   clk, rst       : clock, asynchronous active-high reset
//   clear          : synchronous restart of the capture window
//   wr_en/wr_addr/wr_data : DRAM write port from the NPU
//   signature      : current MISR state
//   sig_valid      : window complete, signature frozen
//   write_count    : writes accepted in this window
//   dropped        : sticky, a write arrived while not collecting
//   single_xor_out : parity of signature
module npu_dram_out_signature
   import npu_sig_pkg::*;
#(
   parameter int                   DWIDTH    = 512,
   parameter int                   AWIDTH    = 9,
   parameter int                   SIG_WIDTH = 32,
   parameter logic [SIG_WIDTH-1:0] POLY      = DefaultPoly,
   parameter logic [SIG_WIDTH-1:0] SEED      = DefaultSeed,
   parameter int unsigned          WINDOW    = 256,
   parameter int                   CWIDTH    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 wr_en,
   input  logic [AWIDTH-1:0]    wr_addr,
   input  logic [DWIDTH-1:0]    wr_data,
   output logic [SIG_WIDTH-1:0] signature,
   output logic                 sig_valid,
   output logic [CWIDTH-1:0]    write_count,
   output logic                 dropped,
   output logic                 single_xor_out
);

   sig_state_e           state_q, state_d;
   logic [SIG_WIDTH-1:0] sig_q, sig_d;
   logic [CWIDTH-1:0]    count_q, count_d;
   logic                 dropped_q, dropped_d;
   logic                 accept;
   logic [CWIDTH-1:0]    count_inc;
   logic [SIG_WIDTH-1:0] s1_fold;
   logic                 s1_valid;
   logic [SigMax-1:0]    sig_step;

   assign accept    = wr_en && (state_q == StCollect) && !clear;
   assign count_inc = count_q + CWIDTH'(1);

   sig_fold #(
      .DWIDTH   (DWIDTH),
      .AWIDTH   (AWIDTH),
      .SIG_WIDTH(SIG_WIDTH)
   ) u_sig_fold (
      .clk     (clk),
      .rst     (rst),
      .flush   (clear),
      .load    (accept),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .s1_fold (s1_fold),
      .s1_valid(s1_valid)
   );

   assign sig_step = misr_step(SigMax'(sig_q), SigMax'(s1_fold), SigMax'(POLY), SIG_WIDTH);

   always_comb begin
      state_d   = state_q;
      sig_d     = sig_q;
      count_d   = count_q;
      dropped_d = dropped_q;
      if (clear) begin
         state_d   = StCollect;
         sig_d     = SEED;
         count_d   = '0;
         dropped_d = 1'b0;
      end else begin
         if (s1_valid) begin
            sig_d = sig_step[SIG_WIDTH-1:0];
         end
         // Saturates instead of wrapping; only reachable when WINDOW is 0.
         if (accept && (count_q != '1)) begin
            count_d = count_inc;
         end
         if (wr_en && (state_q != StCollect)) begin
            dropped_d = 1'b1;
         end
         unique case (state_q)
            StCollect: begin
               if (accept && (WINDOW != 0) && (count_inc == CWIDTH'(WINDOW))) begin
                  state_d = StDrain;
               end
            end
            // Lets the last stage-1 entry reach the MISR before freezing.
            StDrain: state_d = StDone;
            StDone:  state_d = StDone;
            default: state_d = StCollect;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StCollect;
         sig_q     <= SEED;
         count_q   <= '0;
         dropped_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         sig_q     <= sig_d;
         count_q   <= count_d;
         dropped_q <= dropped_d;
      end
   end

   assign signature      = sig_q;
   assign sig_valid      = (state_q == StDone);
   assign write_count    = count_q;
   assign dropped        = dropped_q;
   assign single_xor_out = ^sig_q;

endmodule

// File: tb/tb_npu_dram_out_signature.sv
// Directed/randomized bench for npu_dram_out_signature with a 4-write window.
module tb_npu_dram_out_signature;

   localparam int DW  = 512;
   localparam int AW  = 9;
   localparam int SW  = 32;
   localparam int CW  = 16;
   localparam int WIN = 4;
   localparam logic [31:0] RefPoly = 32'h04C11DB7;
   localparam logic [31:0] RefSeed = 32'hFFFFFFFF;

   logic          clk = 1'b0;
   logic          rst;
   logic          clear;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [SW-1:0] signature;
   logic          sig_valid;
   logic [CW-1:0] write_count;
   logic          dropped;
   logic          single_xor_out;

   int n_assert = 0;
   int n_fail   = 0;

   // Accepted writes of the current window, in order.
   logic [DW-1:0] hist_d[$];
   logic [AW-1:0] hist_a[$];

   npu_dram_out_signature #(
      .DWIDTH   (DW),
      .AWIDTH   (AW),
      .SIG_WIDTH(SW),
      .WINDOW   (WIN),
      .CWIDTH   (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .clear         (clear),
      .wr_en         (wr_en),
      .wr_addr       (wr_addr),
      .wr_data       (wr_data),
      .signature     (signature),
      .sig_valid     (sig_valid),
      .write_count   (write_count),
      .dropped       (dropped),
      .single_xor_out(single_xor_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Column parity of the data viewed as 16 rows of 32 bits, then address mixed in.
   function automatic logic [31:0] ref_fold(input logic [DW-1:0] d, input logic [AW-1:0] a);
      logic [31:0] f;
      for (int j = 0; j < 32; j++) begin
         f[j] = 1'b0;
         for (int i = 0; i < DW / 32; i++) f[j] = f[j] ^ d[32*i+j];
      end
      return f ^ {23'd0, a};
   endfunction

   // Signature after the first n accepted writes: multiply by x modulo the
   // polynomial and add each folded word.
   function automatic logic [31:0] ref_sig(input int n);
      logic [32:0] s;
      s = {1'b0, RefSeed};
      for (int k = 0; k < n; k++) begin
         s = s << 1;
         if (s[32]) s = s ^ {1'b1, RefPoly};
         s[31:0] = s[31:0] ^ ref_fold(hist_d[k], hist_a[k]);
      end
      return s[31:0];
   endfunction

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_write(input logic [DW-1:0] d, input logic [AW-1:0] a, input bit record);
      wr_en   = 1'b1;
      wr_data = d;
      wr_addr = a;
      if (record) begin
         hist_d.push_back(d);
         hist_a.push_back(a);
      end
      tick();
      wr_en = 1'b0;
   endtask

   // Asynchronous pulse between clock edges.
   task automatic pulse_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      hist_d.delete();
      hist_a.delete();
      tick();
   endtask

   logic [DW-1:0] ones;

   initial begin
      rst     = 1'b1;
      clear   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      ones    = '1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) tick();

      // Reset state
      chk("rst_sig", signature, 32'hFFFFFFFF);
      chk("rst_valid", sig_valid, 0);
      chk("rst_count", write_count, 0);
      chk("rst_xor", single_xor_out, 0);
      chk("rst_dropped", dropped, 0);

      // Single zero write, two-edge latency
      do_write('0, '0, 1'b1);
      chk("zero_latency", signature, 32'hFFFFFFFF);
      chk("zero_count", write_count, 1);
      tick();
      chk("zero_sig", signature, 32'hFB3EE249);
      chk("zero_xor", single_xor_out, 1);

      // All-ones data folds to zero
      pulse_reset();
      do_write(ones, '0, 1'b1);
      tick();
      chk("ones_sig", signature, 32'hFB3EE249);
      pulse_reset();
      do_write(ones, 9'h1FF, 1'b1);
      tick();
      chk("ones_addr_sig", signature, ref_sig(1));
      chk("ones_addr_xor", single_xor_out, ^ref_sig(1));

      // Random single write
      pulse_reset();
      do_write(rand_data(), AW'($urandom_range(0, 511)), 1'b1);
      tick();
      chk("rand1_sig", signature, ref_sig(1));

      // Window of 4: six back-to-back writes, only the first four count
      pulse_reset();
      for (int k = 0; k < 6; k++) begin
         do_write(rand_data(), AW'($urandom_range(0, 511)), k < WIN);
         wr_en = (k < 5);
         if (k == 3) begin
            chk("win_drain_valid", sig_valid, 0);
            chk("win_drain_count", write_count, 4);
         end
         if (k == 4) begin
            chk("win_done_valid", sig_valid, 1);
            chk("win_done_sig", signature, ref_sig(WIN));
         end
      end
      wr_en = 1'b0;
      repeat (2) tick();
      chk("win_count", write_count, 4);
      chk("win_sig_hold", signature, ref_sig(WIN));
      chk("win_valid_hold", sig_valid, 1);
      chk("win_dropped", dropped, 1);

      // Clear out of DONE
      clear = 1'b1;
      tick();
      clear = 1'b0;
      hist_d.delete();
      hist_a.delete();
      chk("clr_done_sig", signature, 32'hFFFFFFFF);
      chk("clr_done_valid", sig_valid, 0);
      chk("clr_done_dropped", dropped, 0);
      chk("clr_done_count", write_count, 0);

      // Clear coincident with a write after three writes
      pulse_reset();
      for (int k = 0; k < 3; k++) do_write(rand_data(), AW'($urandom_range(0, 511)), 1'b1);
      clear = 1'b1;
      do_write(rand_data(), AW'($urandom_range(0, 511)), 1'b0);
      clear = 1'b0;
      hist_d.delete();
      hist_a.delete();
      chk("clr_sig", signature, 32'hFFFFFFFF);
      chk("clr_count", write_count, 0);
      chk("clr_dropped", dropped, 0);
      tick();
      chk("clr_flushed_sig", signature, 32'hFFFFFFFF);
      do_write('0, '0, 1'b1);
      tick();
      chk("clr_after_sig", signature, 32'hFB3EE249);
      chk("clr_after_count", write_count, 1);

      // Asynchronous reset while in DRAIN
      pulse_reset();
      for (int k = 0; k < WIN; k++) do_write(rand_data(), AW'($urandom_range(0, 511)), 1'b1);
      chk("drain_count", write_count, 4);
      chk("drain_sig", signature, ref_sig(WIN - 1));
      #2 rst = 1'b1;
      #1;
      chk("arst_sig", signature, 32'hFFFFFFFF);
      chk("arst_count", write_count, 0);
      chk("arst_valid", sig_valid, 0);
      chk("arst_dropped", dropped, 0);
      chk("arst_xor", single_xor_out, 0);
      #1 rst = 1'b0;
      hist_d.delete();
      hist_a.delete();
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("arst_no_valid", sig_valid, 0);
         chk("arst_sig_idle", signature, 32'hFFFFFFFF);
      end
      do_write(rand_data(), AW'($urandom_range(0, 511)), 1'b1);
      tick();
      chk("arst_collect_count", write_count, 1);
      chk("arst_collect_sig", signature, ref_sig(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
